// File: rtl/q4_pkg.sv
// Shared types and constants for the q4 cell self-test engine.
package q4_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StApply,
      StCheck,
      StDone
   } q4_state_e;

   // Full-adder truth tables, indexed by {a,b,c}.
   localparam logic [7:0] Q4_EXP_D = 8'h96;
   localparam logic [7:0] Q4_EXP_E = 8'hE8;

   localparam int unsigned Q4_SETTLE_MAX = 15;
   localparam int unsigned Q4_CNT_W      = $clog2(Q4_SETTLE_MAX + 1);

endpackage

// File: rtl/q4_vec_sequencer.sv
// Vector index and settle counter for the q4 self-test walk.
module q4_vec_sequencer
   import q4_pkg::*;
#(
   parameter int unsigned SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       step,
   input  logic       advance,
   output logic [2:0] vec,
   output logic       last_settle,
   output logic       last_vec
);

   localparam logic [Q4_CNT_W-1:0] SettleLast = Q4_CNT_W'(SETTLE - 1);

   logic [2:0]          vec_q, vec_d;
   logic [Q4_CNT_W-1:0] cnt_q, cnt_d;

   // The count holds at its last value so a one-cycle APPLY works with SETTLE=1.
   always_comb begin
      vec_d = vec_q;
      cnt_d = cnt_q;
      if (clear) begin
         vec_d = 3'd0;
         cnt_d = '0;
      end else if (advance) begin
         vec_d = vec_q + 3'd1;
         cnt_d = '0;
      end else if (step && !last_settle) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q <= 3'd0;
         cnt_q <= '0;
      end else begin
         vec_q <= vec_d;
         cnt_q <= cnt_d;
      end
   end

   assign vec         = vec_q;
   assign last_settle = (cnt_q == SettleLast);
   assign last_vec    = (vec_q == 3'd7);

endmodule

// File: rtl/q4_bist_checker.sv
// Walks all eight input vectors into the q4 cell and checks d/e against truth tables.
module q4_bist_checker
   import q4_pkg::*;
#(
   parameter int unsigned SETTLE = 4,
   parameter logic [7:0]  EXP_D  = Q4_EXP_D,
   parameter logic [7:0]  EXP_E  = Q4_EXP_E
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   input  logic       d,
   input  logic       e,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_vec,
   output logic [3:0] err_count
);

   q4_state_e  state_q, state_d;
   logic [2:0] vec;
   logic       last_settle, last_vec;
   logic       clear, step, advance, mismatch;
   logic [7:0] fail_vec_q, fail_vec_d;
   logic [3:0] err_q, err_d;
   logic       pass_q, pass_d;

   assign clear    = start && ((state_q == StIdle) || (state_q == StDone));
   assign step     = (state_q == StApply);
   assign advance  = (state_q == StCheck) && !last_vec;
   assign mismatch = (d != EXP_D[vec]) || (e != EXP_E[vec]);

   q4_vec_sequencer #(
      .SETTLE (SETTLE)
   ) u_seq (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .step        (step),
      .advance     (advance),
      .vec         (vec),
      .last_settle (last_settle),
      .last_vec    (last_vec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StApply;
         StApply: if (last_settle) state_d = StCheck;
         StCheck: state_d = last_vec ? StDone : StApply;
         StDone:  if (start) state_d = StApply;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      {a, b, c}   = 3'b000;
      unique case (state_q)
         StApply, StCheck: begin
            busy      = 1'b1;
            {a, b, c} = vec;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // Vector 7's result and pass are written on the same edge that enters DONE.
   always_comb begin
      fail_vec_d = fail_vec_q;
      err_d      = err_q;
      pass_d     = pass_q;
      if (clear) begin
         fail_vec_d = 8'h00;
         err_d      = 4'd0;
         pass_d     = 1'b0;
      end else if (state_q == StCheck) begin
         if (mismatch) begin
            fail_vec_d = fail_vec_q | (8'h01 << vec);
            err_d      = err_q + 4'd1;
         end
         if (last_vec) pass_d = (err_d == 4'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fail_vec_q <= 8'h00;
         err_q      <= 4'd0;
         pass_q     <= 1'b0;
      end else begin
         fail_vec_q <= fail_vec_d;
         err_q      <= err_d;
         pass_q     <= pass_d;
      end
   end

   assign fail_vec  = fail_vec_q;
   assign err_count = err_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_q4_bist_checker.sv
// Directed bench for q4_bist_checker with a behavioural full-adder cell and injectable faults.
module tb_q4_bist_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic       a0, b0, c0, d0, e0, busy0, done0, pass0;
   logic       a1, b1, c1, d1, e1, busy1, done1, pass1;
   logic [7:0] fail_vec0, fail_vec1;
   logic [3:0] err0, err1;
   int         fault = 0;   // 0 golden, 1 d stuck-at-0, 2 e inverted
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   // Cell models: full adder, optionally faulted on instance 0.
   assign d0 = (fault == 1) ? 1'b0 : (a0 ^ b0 ^ c0);
   assign e0 = ((a0 & b0) | (a0 & c0) | (b0 & c0)) ^ (fault == 2);
   assign d1 = a1 ^ b1 ^ c1;
   assign e1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

   q4_bist_checker #(
      .SETTLE (4)
   ) dut0 (
      .clk       (clk),
      .rst       (rst),
      .start     (start0),
      .a         (a0),
      .b         (b0),
      .c         (c0),
      .d         (d0),
      .e         (e0),
      .busy      (busy0),
      .done      (done0),
      .pass      (pass0),
      .fail_vec  (fail_vec0),
      .err_count (err0)
   );

   q4_bist_checker #(
      .SETTLE (1)
   ) dut1 (
      .clk       (clk),
      .rst       (rst),
      .start     (start1),
      .a         (a1),
      .b         (b1),
      .c         (c1),
      .d         (d1),
      .e         (e1),
      .busy      (busy1),
      .done      (done1),
      .pass      (pass1),
      .fail_vec  (fail_vec1),
      .err_count (err1)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start pulse sampled at edge T; walks cycles T+1..T+41 checking cadence and results.
   task automatic run0(input int fault_sel, input bit start_mid,
                       input logic [7:0] exp_fv, input logic [3:0] exp_err);
      fault  = fault_sel;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         check("vec_abc", {a0, b0, c0}, (n - 1) / 5);
         check("run_busy", busy0, 1);
         check("run_done", done0, 0);
         start0 = start_mid && (((n - 1) / 5) == 3);
         tick();
      end
      check("end_done", done0, 1);
      check("end_busy", busy0, 0);
      check("end_abc", {a0, b0, c0}, 0);
      check("end_pass", pass0, (exp_err == 0));
      check("end_fail_vec", fail_vec0, exp_fv);
      check("end_err_count", err0, exp_err);
      tick();
      check("hold_done", done0, 1);
      check("hold_fail_vec", fail_vec0, exp_fv);
   endtask

   initial begin
      tick();
      tick();
      check("rst_abc", {a0, b0, c0}, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_pass", pass0, 0);
      check("rst_fail_vec", fail_vec0, 0);
      check("rst_err_count", err0, 0);
      check("rst1_done", done1, 0);
      rst = 1'b0;
      tick();
      check("idle_busy", busy0, 0);

      run0(0, 1'b0, 8'h00, 4'd0);
      run0(1, 1'b0, 8'h96, 4'd4);
      run0(2, 1'b0, 8'hFF, 4'd8);

      // Restart from DONE with failures recorded.
      fault  = 0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("restart_done", done0, 0);
      check("restart_busy", busy0, 1);
      check("restart_fail_vec", fail_vec0, 0);
      check("restart_err_count", err0, 0);
      check("restart_pass", pass0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      run0(0, 1'b1, 8'h00, 4'd0);

      // Reset during vector 5 after a partially failing run.
      fault  = 2;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int n = 1; n < 26; n++) tick();
      check("mid_abc_v5", {a0, b0, c0}, 5);
      check("mid_err_before_rst", err0, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_abc", {a0, b0, c0}, 0);
      check("mrst_busy", busy0, 0);
      check("mrst_done", done0, 0);
      check("mrst_pass", pass0, 0);
      check("mrst_fail_vec", fail_vec0, 0);
      check("mrst_err_count", err0, 0);
      tick();
      tick();
      check("mrst_idle_busy", busy0, 0);
      run0(0, 1'b0, 8'h00, 4'd0);

      // SETTLE=1: two cycles per vector, done 16 cycles after busy rises.
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         check("s1_abc", {a1, b1, c1}, (n - 1) / 2);
         check("s1_busy", busy1, 1);
         check("s1_done", done1, 0);
         tick();
      end
      check("s1_end_done", done1, 1);
      check("s1_end_busy", busy1, 0);
      check("s1_end_pass", pass1, 1);
      check("s1_end_fail_vec", fail_vec1, 0);
      check("s1_end_err_count", err1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
